// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : memory-access pipeline stage (execute -> MEM -> writeback)
//
// Takes the execute stage's effective address / ALU result, store operand,
// destination register and load/store controls. Loads and stores are issued
// to the data-memory port with a strobe that is held until dmem_resp_i.
// Load data is sign- or zero-extended. One result per retired instruction
// is registered toward writeback.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   mem_valid_i      : instruction presented by execute
//   mem_read_i       : load
//   mem_write_i      : store
//   mem_funct3_i     : RV32I access size / signedness
//   mem_alu_out_i    : effective address or ALU result
//   mem_rs2_out_i    : store data
//   mem_rd_i         : destination register
//   mem_stall_o      : combinational stall toward execute
//   dmem_address_o   : word-aligned request address
//   dmem_read_o      : load strobe, held until response
//   dmem_write_o     : store strobe, held until response
//   dmem_wdata_o     : lane-replicated store data
//   dmem_mbe_o       : byte enables
//   dmem_rdata_i     : read data, valid with dmem_resp_i
//   dmem_resp_i      : one-cycle response completing the request
//   wb_valid_o       : one-cycle retire pulse
//   wb_rd_o          : retired destination register
//   wb_data_o        : retired result (load data, ALU result, or 0 for stores)
//   mem_misalign_o   : misaligned-access pulse (only with MEM_MISALIGN_TRAP_EN)
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses are not issued; they raise a
//               one-cycle mem_misalign_o pulse and retire nothing.
//   undefined : low address bits are masked to natural alignment and the
//               access proceeds normally; mem_misalign_o does not exist.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [width-1:0] mem_alu_out_i,
  input  logic [width-1:0] mem_rs2_out_i,
  input  logic [4:0]       mem_rd_i,
  output logic             mem_stall_o,
  output logic [width-1:0] dmem_address_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [width-1:0] dmem_wdata_o,
  output logic [3:0]       dmem_mbe_o,
  input  logic [width-1:0] dmem_rdata_i,
  input  logic             dmem_resp_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [width-1:0] wb_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             mem_misalign_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [0:0]       state_r;
  logic             req_read_r;
  logic             req_write_r;
  logic [width-1:0] addr_r;
  logic [1:0]       ofs_r;
  logic [2:0]       funct3_r;
  logic [4:0]       rd_r;
  logic [width-1:0] wdata_r;
  logic [3:0]       mbe_r;
  logic             wb_valid_r;
  logic [4:0]       wb_rd_r;
  logic [width-1:0] wb_data_r;

  logic             is_mem_s;
  logic [1:0]       size_s;
  logic [1:0]       ofs_s;
  logic             trap_s;
  logic             accept_s;
  logic [3:0]       mbe_s;
  logic [width-1:0] wdata_s;
  logic [width-1:0] shifted_s;
  logic [width-1:0] load_data_s;
  logic             stall_s;

`ifdef MEM_MISALIGN_TRAP_EN
  logic             misalign_s;
  logic             misalign_r;
`endif

  // Request decode: size, aligned byte offset, byte enables and store lanes.
  always_comb begin
    is_mem_s = mem_valid_i & (mem_read_i | mem_write_i);
    size_s   = mem_funct3_i[1:0];
    // Offset is forced to the natural alignment; in trap builds misaligned
    // accesses never reach the port, so the masking is harmless there too.
    case (size_s)
      SIZE_BYTE: ofs_s = mem_alu_out_i[1:0];
      SIZE_HALF: ofs_s = {mem_alu_out_i[1], 1'b0};
      default:   ofs_s = 2'b00;
    endcase
    if (mem_read_i) begin
      mbe_s = 4'b1111;
    end else begin
      case (size_s)
        SIZE_BYTE: mbe_s = 4'b0001 << ofs_s;
        SIZE_HALF: mbe_s = 4'b0011 << ofs_s;
        default:   mbe_s = 4'b1111;
      endcase
    end
    case (size_s)
      SIZE_BYTE: wdata_s = {4{mem_rs2_out_i[7:0]}};
      SIZE_HALF: wdata_s = {2{mem_rs2_out_i[15:0]}};
      default:   wdata_s = mem_rs2_out_i;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment detection for the trapping configuration.
  always_comb begin
    if (size_s == SIZE_BYTE) begin
      misalign_s = 1'b0;
    end else if (size_s == SIZE_HALF) begin
      misalign_s = mem_alu_out_i[0];
    end else begin
      misalign_s = (mem_alu_out_i[1:0] != 2'b00);
    end
    trap_s = is_mem_s & misalign_s;
  end
`else
  assign trap_s = 1'b0;
`endif

  // Acceptance of a memory op and the upstream stall.
  always_comb begin
    accept_s = (state_r == IDLE) & is_mem_s & ~trap_s;
    case (state_r)
      IDLE:    stall_s = accept_s;
      BUSY:    stall_s = ~dmem_resp_i;
      default: stall_s = 1'b0;
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend by funct3.
  always_comb begin
    shifted_s = dmem_rdata_i >> {ofs_r, 3'b000};
    case (funct3_r)
      3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b100:  load_data_s = {24'd0, shifted_s[7:0]};
      3'b101:  load_data_s = {16'd0, shifted_s[15:0]};
      default: load_data_s = dmem_rdata_i;
    endcase
  end

  // FSM, latched request and registered writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      req_read_r  <= 1'b0;
      req_write_r <= 1'b0;
      addr_r      <= '0;
      ofs_r       <= 2'b00;
      funct3_r    <= 3'b000;
      rd_r        <= 5'd0;
      wdata_r     <= '0;
      mbe_r       <= 4'b0000;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_data_r   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r  <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r <= (state_r == IDLE) & trap_s;
`endif
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= BUSY;
            req_read_r  <= mem_read_i;
            // A read wins if both controls are (illegally) high.
            req_write_r <= mem_write_i & ~mem_read_i;
            addr_r      <= {mem_alu_out_i[width-1:2], 2'b00};
            ofs_r       <= ofs_s;
            funct3_r    <= mem_funct3_i;
            rd_r        <= mem_rd_i;
            wdata_r     <= wdata_s;
            mbe_r       <= mbe_s;
            wb_valid_r  <= 1'b0;
          end else if (mem_valid_i & ~is_mem_s) begin
            wb_valid_r <= 1'b1;
            wb_rd_r    <= mem_rd_i;
            wb_data_r  <= mem_alu_out_i;
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_resp_i) begin
            state_r     <= IDLE;
            req_read_r  <= 1'b0;
            req_write_r <= 1'b0;
            wb_valid_r  <= 1'b1;
            wb_rd_r     <= rd_r;
            wb_data_r   <= req_read_r ? load_data_s : '0;
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_read_r  <= 1'b0;
          req_write_r <= 1'b0;
          wb_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_stall_o    = stall_s;
  assign dmem_address_o = addr_r;
  assign dmem_read_o    = req_read_r;
  assign dmem_write_o   = req_write_r;
  assign dmem_wdata_o   = wdata_r;
  assign dmem_mbe_o     = mbe_r;
  assign wb_valid_o     = wb_valid_r;
  assign wb_rd_o        = wb_rd_r;
  assign wb_data_o      = wb_data_r;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign_o = misalign_r;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level model predicts every
// retirement (cycle, rd, data) and each memory request's address, enables and
// store lanes; a per-cycle compare process checks the writeback port, and
// directed tests pin the model with hand-computed literals.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_read_i, mem_write_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_alu_out_i, mem_rs2_out_i;
  logic [4:0]  mem_rd_i;
  logic        mem_stall_o;
  logic [31:0] dmem_address_o;
  logic        dmem_read_o, dmem_write_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_mbe_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_resp_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign_o;
`endif

  mem_stage #(.width(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_funct3_i(mem_funct3_i), .mem_alu_out_i(mem_alu_out_i),
    .mem_rs2_out_i(mem_rs2_out_i), .mem_rd_i(mem_rd_i),
    .mem_stall_o(mem_stall_o), .dmem_address_o(dmem_address_o),
    .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_mbe_o(dmem_mbe_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_resp_i(dmem_resp_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .mem_misalign_o(mem_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  misalign_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extended load value from the word, byte offset and access size.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int ofs, input logic [31:0] rdata);
    int          size;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    v = rdata >> (8 * ofs);
    if (size == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Per-cycle writeback comparison against the model queue.
  always @(negedge clk) begin
    logic exp_v;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL wb_missing rd=%0d expected at cycle %0d, now %0d", exp_q[0].rd, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("wb_valid", {31'd0, wb_valid_o}, {31'd0, exp_v});
    if (exp_v) begin
      if (wb_valid_o) begin
        chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, exp_q[0].rd});
        chk("wb_data", wb_data_o, exp_q[0].data);
      end
      void'(exp_q.pop_front());
    end
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalign", {31'd0, mem_misalign_o}, {31'd0, (cyc == misalign_cyc)});
`endif
  end

  // Present one instruction at a negedge, act as the memory with the given
  // response latency, and return at the negedge after its retirement edge.
  task automatic run_op(input logic v, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic [31:0] rdata, input int lat,
                        output int stalls, output logic [31:0] s_addr,
                        output logic [3:0] s_mbe, output logic [31:0] s_wdata);
    int          size, a, ea;
    logic        memop, trap;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_mbe;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a     = int'(addr[1:0]);
    ea    = a - (a % size);
    memop = v && (rd_en || wr_en);
`ifdef MEM_MISALIGN_TRAP_EN
    trap  = memop && ((a % size) != 0);
`else
    trap  = 1'b0;
`endif
    e_addr = addr & 32'hFFFF_FFFC;
    e_mbe  = rd_en ? 4'hF : 4'(((1 << size) - 1) << ea);
    e_wd   = (size == 1) ? {24'd0, rs2[7:0]} * 32'h0101_0101 :
             (size == 2) ? {16'd0, rs2[15:0]} * 32'h0001_0001 : rs2;
    stalls = 0; s_addr = 32'd0; s_mbe = 4'd0; s_wdata = 32'd0;
    mem_valid_i = v; mem_read_i = rd_en; mem_write_i = wr_en; mem_funct3_i = f3;
    mem_alu_out_i = addr; mem_rs2_out_i = rs2; mem_rd_i = rd;
    if (v && !memop) exp_q.push_back('{cyc + 1, rd, addr});
    else if (trap) misalign_cyc = cyc + 1;
    else if (memop) exp_q.push_back('{cyc + lat + 1, rd, rd_en ? exp_load(f3, ea, rdata) : 32'd0});
    #1;
    chk("idle_strobes", {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
    chk("idle_stall", {31'd0, mem_stall_o}, {31'd0, memop && !trap});
    stalls += int'(mem_stall_o);
    if (memop && !trap) begin
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk);
        @(negedge clk);
        dmem_resp_i  = (k == lat);
        dmem_rdata_i = rdata;
        #1;
        chk("strobe_rd", {31'd0, dmem_read_o}, {31'd0, rd_en});
        chk("strobe_wr", {31'd0, dmem_write_o}, {31'd0, wr_en && !rd_en});
        chk("dmem_addr", dmem_address_o, e_addr);
        chk("dmem_mbe", {28'd0, dmem_mbe_o}, {28'd0, e_mbe});
        if (wr_en) chk("dmem_wdata", dmem_wdata_o, e_wd);
        chk("busy_stall", {31'd0, mem_stall_o}, {31'd0, k != lat});
        stalls += int'(mem_stall_o);
        s_addr = dmem_address_o; s_mbe = dmem_mbe_o; s_wdata = dmem_wdata_o;
      end
    end
    @(posedge clk);
    @(negedge clk);
    dmem_resp_i = 1'b0;
    mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] sa, sw;
    logic [3:0]  sm;
    rst = 1'b1;
    mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_funct3_i = 3'd0;
    mem_alu_out_i = 32'd0; mem_rs2_out_i = 32'd0; mem_rd_i = 5'd0;
    dmem_rdata_i = 32'd0; dmem_resp_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("reset_wb_data", wb_data_o, 32'd0);
    chk("reset_strobes", {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU passthrough
    run_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 32'd0, 1, st, sa, sm, sw);
    chk("alu_lit_data", wb_data_o, 32'h1234_5678);
    chk("alu_lit_rd", {27'd0, wb_rd_o}, 32'd5);
    chk("alu_lit_stall", st, 32'd0);

    // LB / LBU at 0x103, three-cycle response
    run_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd9, 32'h80FF_FF7F, 3, st, sa, sm, sw);
    chk("lb_lit_addr", sa, 32'h0000_0100);
    chk("lb_lit_mbe", {28'd0, sm}, 32'h0000_000F);
    chk("lb_lit_stall", st, 32'd3);
    chk("lb_lit_data", wb_data_o, 32'hFFFF_FF80);
    run_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd10, 32'h80FF_FF7F, 3, st, sa, sm, sw);
    chk("lbu_lit_data", wb_data_o, 32'h0000_0080);

    // SH at 0x202
    run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd11, 32'h0, 2, st, sa, sm, sw);
    chk("sh_lit_mbe", {28'd0, sm}, 32'h0000_000C);
    chk("sh_lit_wdata", sw, 32'hBEEF_BEEF);
    chk("sh_lit_data", wb_data_o, 32'd0);

    // Further size/lane patterns (model-checked)
    run_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 5'd12, 32'h8001_0000, 1, st, sa, sm, sw);
    chk("lh_lit_data", wb_data_o, 32'hFFFF_8001);
    run_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0106, 32'd0, 5'd13, 32'h8001_1234, 2, st, sa, sm, sw);
    run_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 5'd14, 32'h0, 1, st, sa, sm, sw);
    chk("sb_lit_mbe", {28'd0, sm}, 32'h0000_0002);
    chk("sb_lit_wdata", sw, 32'hA5A5_A5A5);
    run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 5'd15, 32'h0, 1, st, sa, sm, sw);
    run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd16, 32'h0, 1, st, sa, sm, sw);
    run_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'd0, 5'd17, 32'h8001_7FFE, 1, st, sa, sm, sw);

    // Misaligned LW at 0x301
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 5'd18, 32'h1122_3344, 1, st, sa, sm, sw);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_lit_pulse", {31'd0, mem_misalign_o}, 32'd1);
    chk("lw_mis_lit_stall", st, 32'd0);
`else
    chk("lw_mis_lit_addr", sa, 32'h0000_0300);
    chk("lw_mis_lit_data", wb_data_o, 32'h1122_3344);
`endif

    // Response while idle is ignored
    dmem_resp_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_resp_i = 1'b0;

    // Back-to-back LW, ADD, LW with one-cycle responses
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd20, 32'hA0A0_0001, 1, st, sa, sm, sw);
    chk("b2b_lw1_stall", st, 32'd1);
    run_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'd0, 5'd21, 32'h0, 1, st, sa, sm, sw);
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'd0, 5'd22, 32'hB0B0_0002, 1, st, sa, sm, sw);
    chk("b2b_lw2_data", wb_data_o, 32'hB0B0_0002);
    @(negedge clk);

    // Reset during an outstanding SW
    mem_valid_i = 1'b1; mem_write_i = 1'b1; mem_funct3_i = 3'b010;
    mem_alu_out_i = 32'h0000_0400; mem_rs2_out_i = 32'h1357_9BDF; mem_rd_i = 5'd7;
    @(posedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0; mem_write_i = 1'b0;
    #1;
    chk("rst_pre_write", {31'd0, dmem_write_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_write_drop", {31'd0, dmem_write_o}, 32'd0);
    chk("rst_read_drop", {31'd0, dmem_read_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_resp_i = 1'b1;
    dmem_rdata_i = 32'h2468_ACE0;
    @(posedge clk);
    @(negedge clk);
    dmem_resp_i = 1'b0;
    #1;
    chk("rst_late_resp", {31'd0, wb_valid_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
